// File: rtl/icb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icb_pkg
// Description : Shared ICB definitions for the MMA controller and the ICB
//               port mux. Holds the master select encodings, the default
//               master count and the tag width used to remember which
//               master issued each outstanding command.
// Revision    : 1.0 - initial release
// ============================================================================
package icb_pkg;

    localparam int ICB_NUM_MASTERS = 5;
    localparam int ICB_TAG_W       = 3;

    typedef enum logic [2:0] {
        ICB_SEL_IA     = 3'd0,
        ICB_SEL_WEIGHT = 3'd1,
        ICB_SEL_BIAS   = 3'd2,
        ICB_SEL_QUANT  = 3'd3,
        ICB_SEL_OA     = 3'd4
    } icb_sel_e;

endpackage
`default_nettype wire

// File: rtl/icb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : icb_tag_fifo
// Description : Synchronous in-order FIFO holding the source master index of
//               every accepted ICB command. The head entry names the master
//               that owns the next slave response.
// Ports       : clk/rst  - clock, synchronous active-high reset
//               push     - write wdata (ignored when full)
//               wdata    - tag to store
//               pop      - drop the head entry (ignored when empty)
//               rdata    - head tag
//               count    - number of stored tags (0..DEPTH)
//               empty    - count == 0
//               full     - count == DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module icb_tag_fifo
    import icb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ICB_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icb_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : icb_port_mux
// Description : Routes the ICB master selected by icb_sel onto the shared
//               slave bus. Each accepted command is tagged with its source
//               index so responses return to the issuing master even after
//               icb_sel has moved on.
// Ports       : clk/rst            - clock, synchronous active-high reset
//               icb_sel            - selected master index
//               m_cmd_*            - packed per-master command channels
//               m_rsp_*            - per-master response valid/ready, shared
//                                    rdata/err qualified by m_rsp_valid[i]
//               s_cmd_* / s_rsp_*  - shared slave bus
//               outstanding / busy - commands accepted but not answered
//               proto_err          - sticky: response with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module icb_port_mux
    import icb_pkg::*;
#(
    parameter int NUM_MASTERS     = ICB_NUM_MASTERS,
    parameter int ADDR_WIDTH      = 32,
    parameter int BUS_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [2:0]                          icb_sel,
    input  logic [NUM_MASTERS-1:0]              m_cmd_valid,
    output logic [NUM_MASTERS-1:0]              m_cmd_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_cmd_addr,
    input  logic [NUM_MASTERS-1:0]              m_cmd_read,
    input  logic [NUM_MASTERS*BUS_WIDTH-1:0]    m_cmd_wdata,
    input  logic [NUM_MASTERS*BUS_WIDTH/8-1:0]  m_cmd_wmask,
    output logic [NUM_MASTERS-1:0]              m_rsp_valid,
    input  logic [NUM_MASTERS-1:0]              m_rsp_ready,
    output logic [BUS_WIDTH-1:0]                m_rsp_rdata,
    output logic                                m_rsp_err,
    output logic                                s_cmd_valid,
    input  logic                                s_cmd_ready,
    output logic [ADDR_WIDTH-1:0]               s_cmd_addr,
    output logic                                s_cmd_read,
    output logic [BUS_WIDTH-1:0]                s_cmd_wdata,
    output logic [BUS_WIDTH/8-1:0]              s_cmd_wmask,
    input  logic                                s_rsp_valid,
    output logic                                s_rsp_ready,
    input  logic [BUS_WIDTH-1:0]                s_rsp_rdata,
    input  logic                                s_rsp_err,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                busy,
    output logic                                proto_err
);

    localparam int                MASK_W  = BUS_WIDTH / 8;
    localparam logic [31:0]       C_NUM_M = NUM_MASTERS;

    logic                  sel_ok;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ICB_TAG_W-1:0]  head;
    logic                  cmd_push;
    logic                  rsp_pop;
    logic                  proto_err_q, proto_err_d;

    assign sel_ok = ({29'd0, icb_sel} < C_NUM_M);

    // Command path: ready never looks at valid, so no loop is formed with
    // masters that wait for ready before raising valid.
    always_comb begin
        s_cmd_valid = 1'b0;
        s_cmd_addr  = '0;
        s_cmd_read  = 1'b0;
        s_cmd_wdata = '0;
        s_cmd_wmask = '0;
        m_cmd_ready = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel_ok && (icb_sel == 3'(i))) begin
                s_cmd_valid    = ~fifo_full & m_cmd_valid[i];
                s_cmd_addr     = m_cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_cmd_read     = m_cmd_read[i];
                s_cmd_wdata    = m_cmd_wdata[i*BUS_WIDTH +: BUS_WIDTH];
                s_cmd_wmask    = m_cmd_wmask[i*MASK_W +: MASK_W];
                m_cmd_ready[i] = ~fifo_full & s_cmd_ready;
            end
        end
    end

    // Response path: the head tag picks the destination. With nothing
    // pending, a stray beat is swallowed so the slave cannot stall.
    always_comb begin
        m_rsp_valid = '0;
        s_rsp_ready = s_rsp_valid;
        if (!fifo_empty) begin
            s_rsp_ready = 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (head == 3'(i)) begin
                    m_rsp_valid[i] = s_rsp_valid;
                    s_rsp_ready    = m_rsp_ready[i];
                end
            end
        end
    end

    assign m_rsp_rdata = s_rsp_rdata;
    assign m_rsp_err   = s_rsp_err;

    assign cmd_push = s_cmd_valid & s_cmd_ready;
    assign rsp_pop  = ~fifo_empty & s_rsp_valid & s_rsp_ready;

    always_comb begin
        proto_err_d = proto_err_q | (fifo_empty & s_rsp_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    icb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ICB_TAG_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .wdata (icb_sel),
        .pop   (rsp_pop),
        .rdata (head),
        .count (outstanding),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign busy      = ~fifo_empty;
    assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_icb_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_icb_port_mux
// Description : Randomized self-checking bench for icb_port_mux. A queue of
//               outstanding source indices stands in for the mux's state;
//               every cycle the expected bus routing is derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icb_port_mux;

    localparam int NM   = 5;
    localparam int AW   = 32;
    localparam int BW   = 32;
    localparam int MW   = BW / 8;
    localparam int MAXO = 4;

    logic                 clk;
    logic                 rst;
    logic [2:0]           icb_sel;
    logic [NM-1:0]        m_cmd_valid;
    logic [NM-1:0]        m_cmd_ready;
    logic [NM*AW-1:0]     m_cmd_addr;
    logic [NM-1:0]        m_cmd_read;
    logic [NM*BW-1:0]     m_cmd_wdata;
    logic [NM*MW-1:0]     m_cmd_wmask;
    logic [NM-1:0]        m_rsp_valid;
    logic [NM-1:0]        m_rsp_ready;
    logic [BW-1:0]        m_rsp_rdata;
    logic                 m_rsp_err;
    logic                 s_cmd_valid;
    logic                 s_cmd_ready;
    logic [AW-1:0]        s_cmd_addr;
    logic                 s_cmd_read;
    logic [BW-1:0]        s_cmd_wdata;
    logic [MW-1:0]        s_cmd_wmask;
    logic                 s_rsp_valid;
    logic                 s_rsp_ready;
    logic [BW-1:0]        s_rsp_rdata;
    logic                 s_rsp_err;
    logic [$clog2(MAXO):0] outstanding;
    logic                 busy;
    logic                 proto_err;

    icb_port_mux #(
        .NUM_MASTERS     (NM),
        .ADDR_WIDTH      (AW),
        .BUS_WIDTH       (BW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .icb_sel     (icb_sel),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_ready (m_cmd_ready),
        .m_cmd_addr  (m_cmd_addr),
        .m_cmd_read  (m_cmd_read),
        .m_cmd_wdata (m_cmd_wdata),
        .m_cmd_wmask (m_cmd_wmask),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_ready (m_rsp_ready),
        .m_rsp_rdata (m_rsp_rdata),
        .m_rsp_err   (m_rsp_err),
        .s_cmd_valid (s_cmd_valid),
        .s_cmd_ready (s_cmd_ready),
        .s_cmd_addr  (s_cmd_addr),
        .s_cmd_read  (s_cmd_read),
        .s_cmd_wdata (s_cmd_wdata),
        .s_cmd_wmask (s_cmd_wmask),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_ready (s_rsp_ready),
        .s_rsp_rdata (s_rsp_rdata),
        .s_rsp_err   (s_rsp_err),
        .outstanding (outstanding),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: source index of every command awaiting a response.
    int tags[$];
    bit model_proto;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, compare combinational and registered outputs
    // against the queue, then advance the queue as the edge will.
    task automatic run_cycle(input bit rst_v, input bit do_check,
                             input int p_cmd, input int p_rsp, input bit idle);
        logic [NM-1:0] exp_ready;
        logic [NM-1:0] exp_rvalid;
        bit            exp_scv;
        bit            exp_srr;
        bit            ok_sel;
        bit            is_full;
        int            sel;
        int            depth;
        bit            do_push;
        bit            do_pop;

        @(posedge clk);
        #1;
        rst = rst_v;
        if (idle) begin
            icb_sel     = 3'd0;
            m_cmd_valid = '0;
            s_cmd_ready = 1'b0;
            m_rsp_ready = '0;
            s_rsp_valid = 1'b0;
        end else begin
            if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 9) < 8) icb_sel = 3'($urandom_range(0, NM - 1));
                else                          icb_sel = 3'($urandom_range(NM, 7));
            end
            for (int i = 0; i < NM; i++) begin
                m_cmd_valid[i]           = ($urandom_range(0, 99) < p_cmd);
                m_cmd_read[i]            = $urandom_range(0, 1) == 1;
                m_cmd_addr[i*AW +: AW]   = $urandom;
                m_cmd_wdata[i*BW +: BW]  = $urandom;
                m_cmd_wmask[i*MW +: MW]  = 4'($urandom);
                m_rsp_ready[i]           = ($urandom_range(0, 99) < 70);
            end
            s_cmd_ready = ($urandom_range(0, 99) < 80);
            if (tags.size() == 0) s_rsp_valid = ($urandom_range(0, 99) < 2);
            else                  s_rsp_valid = ($urandom_range(0, 99) < p_rsp);
            s_rsp_rdata = $urandom;
            s_rsp_err   = $urandom_range(0, 1) == 1;
        end
        #2;

        depth   = tags.size();
        sel     = int'(icb_sel);
        ok_sel  = (sel < NM);
        is_full = (depth == MAXO);

        exp_ready = '0;
        exp_scv   = 1'b0;
        if (ok_sel && !is_full) begin
            exp_ready[sel] = s_cmd_ready;
            exp_scv        = m_cmd_valid[sel];
        end

        exp_rvalid = '0;
        if (depth > 0) begin
            exp_rvalid[tags[0]] = s_rsp_valid;
            exp_srr             = m_rsp_ready[tags[0]];
        end else begin
            exp_srr = s_rsp_valid;
        end

        if (do_check) begin
            check_val("m_cmd_ready", m_cmd_ready, exp_ready);
            check_val("s_cmd_valid", s_cmd_valid, exp_scv);
            if (ok_sel) begin
                check_val("s_cmd_addr",  s_cmd_addr,  m_cmd_addr[sel*AW +: AW]);
                check_val("s_cmd_read",  s_cmd_read,  m_cmd_read[sel]);
                check_val("s_cmd_wdata", s_cmd_wdata, m_cmd_wdata[sel*BW +: BW]);
                check_val("s_cmd_wmask", s_cmd_wmask, m_cmd_wmask[sel*MW +: MW]);
            end
            check_val("m_rsp_valid", m_rsp_valid, exp_rvalid);
            check_val("s_rsp_ready", s_rsp_ready, exp_srr);
            check_val("m_rsp_rdata", m_rsp_rdata, s_rsp_rdata);
            check_val("m_rsp_err",   m_rsp_err,   s_rsp_err);
            check_val("outstanding", outstanding, depth);
            check_val("busy",        busy,        depth != 0);
            check_val("proto_err",   proto_err,   model_proto);
        end

        do_push = exp_scv && s_cmd_ready;
        do_pop  = (depth > 0) && s_rsp_valid && exp_srr;
        if (rst_v) begin
            tags.delete();
            model_proto = 1'b0;
        end else begin
            if (do_pop)  void'(tags.pop_front());
            if (do_push) tags.push_back(sel);
            if (depth == 0 && s_rsp_valid) model_proto = 1'b1;
        end
    endtask

    initial begin
        int p_cmd;
        int p_rsp;
        rst         = 1'b1;
        icb_sel     = 3'd0;
        m_cmd_valid = '0;
        m_cmd_addr  = '0;
        m_cmd_read  = '0;
        m_cmd_wdata = '0;
        m_cmd_wmask = '0;
        m_rsp_ready = '0;
        s_cmd_ready = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_rdata = '0;
        s_rsp_err   = 1'b0;
        model_proto = 1'b0;

        run_cycle(1'b1, 1'b0, 0, 0, 1'b1);
        run_cycle(1'b1, 1'b0, 0, 0, 1'b1);
        run_cycle(1'b0, 1'b1, 0, 0, 1'b1);   // post-reset idle state

        // Phases alternate between filling (rare responses) and draining
        // (rare commands), with occasional resets mid-traffic.
        for (int ph = 0; ph < 24; ph++) begin
            case (ph % 4)
                0: begin p_cmd = 80; p_rsp = 10; end
                1: begin p_cmd = 10; p_rsp = 80; end
                2: begin p_cmd = 60; p_rsp = 60; end
                default: begin p_cmd = 90; p_rsp = 90; end
            endcase
            for (int c = 0; c < 150; c++) begin
                run_cycle(($urandom_range(0, 199) == 0), 1'b1, p_cmd, p_rsp, 1'b0);
            end
        end

        run_cycle(1'b1, 1'b1, 0, 0, 1'b1);
        run_cycle(1'b0, 1'b1, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icb_port_mux.md
# icb_port_mux

- Routes the ICB master port selected by the MMA controller's `icb_sel` onto the single shared ICB slave bus.
- The five masters are the IA loader, weight loader, bias loader, requant parameter fetch and OA writer.
- Tags every accepted command with its source index in an in-order tag FIFO, so each response returns to the master that issued it even after `icb_sel` changes.
- Sits directly downstream of the controller's `icb_sel` output and upstream of the system ICB interconnect.

## Interface
Parameters:
- `NUM_MASTERS`, 5, number of master ports; `icb_sel` encodings 0..NUM_MASTERS-1.
- `ADDR_WIDTH`, 32, ICB address width.
- `BUS_WIDTH`, 32, ICB data width; wmask width is BUS_WIDTH/8.
- `MAX_OUTSTANDING`, 4, tag FIFO depth; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `icb_sel`  in  3  selected master index.
- `m_cmd_valid` / `m_cmd_ready`  in / out  NUM_MASTERS  per-master command handshake.
- `m_cmd_addr`  in  NUM_MASTERS*ADDR_WIDTH  packed; master i occupies slice i.
- `m_cmd_read`  in  NUM_MASTERS  1 = read, 0 = write.
- `m_cmd_wdata`  in  NUM_MASTERS*BUS_WIDTH  packed write data.
- `m_cmd_wmask`  in  NUM_MASTERS*BUS_WIDTH/8  packed byte mask.
- `m_rsp_valid` / `m_rsp_ready`  out / in  NUM_MASTERS  per-master response handshake.
- `m_rsp_rdata`  out  BUS_WIDTH  shared read data; qualified by `m_rsp_valid[i]`.
- `m_rsp_err`  out  1  shared error bit; qualified by `m_rsp_valid[i]`.
- `s_cmd_valid` / `s_cmd_ready`  out / in  1  slave command handshake.
- `s_cmd_addr`, `s_cmd_read`, `s_cmd_wdata`, `s_cmd_wmask`  out  slave command fields.
- `s_rsp_valid` / `s_rsp_ready`  in / out  1  slave response handshake.
- `s_rsp_rdata`  in  BUS_WIDTH  slave read data.
- `s_rsp_err`  in  1  slave error bit.
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  commands accepted but not yet answered.
- `busy`  out  1  asserted while `outstanding != 0`.
- `proto_err`  out  1  sticky; set by a slave response arriving while no command is outstanding.

## Operation
- `sel_ok = icb_sel < NUM_MASTERS`; `full = (outstanding == MAX_OUTSTANDING)`.
- Command path, combinational:
  - `s_cmd_valid = sel_ok & ~full & m_cmd_valid[icb_sel]`.
  - `s_cmd_*` fields come from slice `icb_sel`.
  - `m_cmd_ready[icb_sel] = sel_ok & ~full & s_cmd_ready`.
  - `m_cmd_ready` is 0 for every other master.
- Command handshake: on `s_cmd_valid & s_cmd_ready`, push `icb_sel` into the tag FIFO.
- Response path:
  - `head` is the tag at the FIFO head.
  - When not empty: `m_rsp_valid[head] = s_rsp_valid`, `s_rsp_ready = m_rsp_ready[head]`.
  - `m_rsp_rdata` and `m_rsp_err` pass through unchanged.
  - On a response handshake, pop the FIFO.
- Empty FIFO while `s_rsp_valid`: the block forces `s_rsp_ready = 1`, drops the beat (no `m_rsp_valid` asserted), and sets `proto_err`. `proto_err` clears only on `rst`.
- Push and pop in the same cycle: `outstanding` is unchanged; the FIFO pointers both advance.
- Full: push is blocked; a pop that cycle frees a slot, which becomes visible the next cycle. A full FIFO therefore never accepts a command in the same cycle it pops.
- `icb_sel` change: takes effect on the command path in the same cycle. Responses still in flight go to their tagged masters, not to the new selection. There is no drain requirement.
- Invalid `icb_sel`: no command is granted; responses still route normally.
- `outstanding` never wraps: pushes are blocked at full and pops are blocked at empty.

## Timing
- Command and response paths are combinational, zero-cycle latency. There is no valid-to-ready combinational loop inside the block.
- `outstanding`, `busy`, `proto_err` and the FIFO pointers are registered and update on the edge after the handshake.
- Reset values:
  - `outstanding = 0`, `busy = 0`, `proto_err = 0`, FIFO empty.
  - Consequently all `m_rsp_valid = 0`, `s_cmd_valid = 0`, `m_cmd_ready = 0` and `s_rsp_ready = 0` unless the slave presents `s_rsp_valid`.
- `rst` asserted mid-transaction discards all tags. The surrounding design resets the slave in the same cycle.
- Throughput: one command per cycle and one response per cycle, concurrently.

## Structure
- Shared package `icb_pkg` holds:
  - `icb_sel_e` encodings: `ICB_SEL_IA=0`, `ICB_SEL_WEIGHT=1`, `ICB_SEL_BIAS=2`, `ICB_SEL_QUANT=3`, `ICB_SEL_OA=4`.
  - The `NUM_MASTERS` default constant.
- The MMA controller imports the same package for its `icb_sel` values.
- One sub-module, `icb_tag_fifo`: synchronous FIFO, DEPTH = MAX_OUTSTANDING, width 3, with a count output that drives `outstanding` directly.

## Test plan
- **Single read.** `icb_sel=1`, weight master issues read at 0x1000, slave returns 0xDEADBEEF after 3 cycles → `m_rsp_valid[1]` with that data; `outstanding` goes 0→1→0.
- **Fill and block.** Slave holds responses; IA master issues 5 back-to-back commands → first 4 accepted, `m_cmd_ready[0]=0` on the 5th while `outstanding=4`. Release one response → 5th accepted the following cycle.
- **Select switch.** IA issues 2 reads, then `icb_sel` changes to 4 and OA issues 1 write → responses arrive in order to masters 0, 0, 4. No response ever appears on master 4 before the IA pair.
- **Backpressure.** `m_rsp_ready[2]=0` for 5 cycles → `s_rsp_ready=0` throughout those cycles; the slave response beat is held stable until `m_rsp_ready[2]` rises.
- **Protocol error.** Inject `s_rsp_valid` with the FIFO empty → beat consumed, no `m_rsp_valid`, `proto_err=1` and held until `rst`.
- **Reset mid-operation.** `rst` pulsed with 3 outstanding → next cycle `outstanding=0`, `busy=0`; `icb_sel=7` → no `m_cmd_ready` asserted.
